// File: rtl/csd_normalizer_pkg.sv
// Shared definitions for the CSD normalizer: digit codes, shift direction and FSM states.
package csd_normalizer_pkg;

   localparam logic [1:0] CSD_ZERO = 2'b00;
   localparam logic [1:0] CSD_POS  = 2'b01;
   localparam logic [1:0] CSD_NEG  = 2'b11;

   localparam logic CSD_SHL = 1'b0;
   localparam logic CSD_SHR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Only 2'b00 is a zero digit; 2'b10 is treated as nonzero.
   function automatic logic digit_nonzero(input logic [1:0] d);
      return d != CSD_ZERO;
   endfunction

endpackage

// File: rtl/barrel_shifter_csd.sv
// Combinational CSD barrel shifter: moves whole 2-bit digits, filling with zero digits.
module barrel_shifter_csd
   import csd_normalizer_pkg::*;
#(
   parameter int W     = 8,
   parameter int LOG2W = 3
) (
   input  logic [2*W-1:0]   csd_in,
   input  logic [LOG2W-1:0] sel,
   input  logic             dir,
   output logic [2*W-1:0]   csd_out
);

   always_comb begin
      csd_out = csd_in;
      for (int b = 0; b < LOG2W; b++) begin
         if (sel[b]) begin
            if (dir == CSD_SHL) csd_out = csd_out << (2 * (2 ** b));
            else                csd_out = csd_out >> (2 * (2 ** b));
         end
      end
   end

endmodule

// File: rtl/csd_normalizer.sv
// Sequential leading-zero-digit normalizer for CSD mantissas; one word in flight at a time.
//
// state    | meaning
// ST_IDLE  | ready for a new word
// ST_SCAN  | stepping cnt MSD-first until a nonzero digit or the last digit
// ST_SHIFT | register shifter output, shift amount and zero flag
// ST_DONE  | result presented, waiting for out_ready
module csd_normalizer
   import csd_normalizer_pkg::*;
#(
   parameter int W     = 8,
   parameter int LOG2W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   in_csd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_csd,
   output logic [LOG2W-1:0] out_shamt,
   output logic             out_zero
);

   state_t           state, state_next;
   logic [2*W-1:0]   word_q;
   logic [LOG2W-1:0] cnt;
   logic             zero_q;
   logic [2*W-1:0]   sh_out;
   logic             msd_nz;
   logic             cnt_last;

   barrel_shifter_csd #(.W(W), .LOG2W(LOG2W)) u_shifter (
      .csd_in  (word_q),
      .sel     (cnt),
      .dir     (CSD_SHL),
      .csd_out (sh_out)
   );

   // After shifting by cnt, the MSD of the shifter output is digit W-1-cnt of word_q.
   assign msd_nz   = digit_nonzero(sh_out[2*W-1 -: 2]);
   assign cnt_last = (cnt == LOG2W'(W - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) state_next = ST_SCAN;
         end
         ST_SCAN: begin
            if (msd_nz || cnt_last) state_next = ST_SHIFT;
         end
         ST_SHIFT: state_next = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q    <= '0;
         cnt       <= '0;
         zero_q    <= 1'b0;
         out_csd   <= '0;
         out_shamt <= '0;
         out_zero  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  word_q <= in_csd;
                  cnt    <= '0;
                  zero_q <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (!msd_nz) begin
                  if (cnt_last) zero_q <= 1'b1;
                  else          cnt    <= cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               out_csd   <= sh_out;
               out_shamt <= zero_q ? '0 : cnt;
               out_zero  <= zero_q;
            end
            ST_DONE: begin
               if (out_ready) zero_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csd_normalizer.sv
// Directed and randomized checks of csd_normalizer against hand-computed results.
module tb_csd_normalizer;

   localparam int W     = 8;
   localparam int LOG2W = 3;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [2*W-1:0]   in_csd    = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [2*W-1:0]   out_csd;
   logic [LOG2W-1:0] out_shamt;
   logic             out_zero;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;
   int n_out    = 0;

   always #5 clk = ~clk;

   csd_normalizer #(.W(W), .LOG2W(LOG2W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_csd    (in_csd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_csd   (out_csd),
      .out_shamt (out_shamt),
      .out_zero  (out_zero)
   );

   always @(posedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready)   n_acc++;
         if (out_valid && out_ready) n_out++;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int csd2bin(input logic [15:0] w);
      int v = 0;
      for (int i = 0; i < W; i++) begin
         if (w[2*i +: 2] == 2'b01) v += (1 << i);
         if (w[2*i +: 2] == 2'b11) v -= (1 << i);
      end
      return v;
   endfunction

   // Offer a word, then count edges after acceptance until out_valid is seen.
   task automatic send_and_wait(input logic [15:0] word, output int lat);
      int guard = 0;
      while (!in_ready && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", 32'(guard < 30), 32'd1);
      in_valid = 1'b1;
      in_csd   = word;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
   endtask

   task automatic run_txn(input logic [15:0] word, input logic [15:0] exp_csd, input int exp_shamt,
                          input bit exp_zero, input int exp_lat, input string tag);
      int lat;
      out_ready = 1'b1;
      send_and_wait(word, lat);
      check({tag, "_lat"},   32'(lat),       32'(exp_lat));
      check({tag, "_csd"},   32'(out_csd),   32'(exp_csd));
      check({tag, "_shamt"}, 32'(out_shamt), 32'(exp_shamt));
      check({tag, "_zero"},  32'(out_zero),  32'(exp_zero));
      @(posedge clk);
      #1;
      check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      int lat;
      int a0, o0;
      bit seen_valid;
      logic [15:0] w, exp_w;
      int k0, k;
      bit found;

      // reset
      @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_csd",   32'(out_csd),   32'd0);
      check("rst_out_shamt", 32'(out_shamt), 32'd0);
      check("rst_out_zero",  32'(out_zero),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // +1,0,-1,0,0,0,0,+1
      run_txn(16'h4C01, 16'h4C01, 0, 1'b0, 2, "msd");
      // 0,0,0,+1,0,-1,0,0 -> +1,0,-1,0,0,0,0,0
      run_txn(16'h0130, 16'h4C00, 3, 1'b0, 5, "k3");
      check("k3_value", 32'(csd2bin(out_csd)), 32'(96));
      run_txn(16'h0000, 16'h0000, 0, 1'b1, 9, "zero");

      // backpressure with k=3
      out_ready = 1'b0;
      send_and_wait(16'h0130, lat);
      check("bp_lat", 32'(lat), 32'd5);
      for (int i = 0; i < 4; i++) begin
         check("bp_csd",      32'(out_csd),   32'h4C00);
         check("bp_shamt",    32'(out_shamt), 32'd3);
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready),  32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rdy_after", 32'(in_ready),  32'd1);
      check("bp_vld_after", 32'(out_valid), 32'd0);

      // reset two cycles into SCAN of 0,0,0,0,0,0,0,-1
      in_valid = 1'b1;
      in_csd   = 16'h0003;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_in_ready",  32'(in_ready),  32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_out_csd",   32'(out_csd),   32'd0);
      check("mrst_out_shamt", 32'(out_shamt), 32'd0);
      check("mrst_out_zero",  32'(out_zero),  32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_rdy_after", 32'(in_ready), 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      check("mrst_no_output", 32'(seen_valid), 32'd0);

      // randomized back-to-back
      a0 = n_acc;
      o0 = n_out;
      for (int t = 0; t < 24; t++) begin
         k0 = $urandom_range(0, 8);
         w  = '0;
         for (int d = 0; d < W; d++) begin
            if (d < W - k0) w[2*d +: 2] = 2'($urandom_range(0, 3));
         end
         found = 1'b0;
         k     = 0;
         for (int d = W - 1; d >= 0; d--) begin
            if (!found && w[2*d +: 2] != 2'b00) begin
               found = 1'b1;
               k     = W - 1 - d;
            end
         end
         if (found) begin
            exp_w = w << (2 * k);
            run_txn(w, exp_w, k, 1'b0, k + 2, "rnd");
         end else begin
            run_txn(w, 16'h0000, 0, 1'b1, W + 1, "rnd");
         end
      end
      check("rnd_accepted", 32'(n_acc - a0), 32'd24);
      check("rnd_produced", 32'(n_out - o0), 32'd24);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
